valid_io: RTL and testbench

- Input-legality checker for the rock-paper-scissors datapath. Sits between the player input capture and the winner-decision logic.
- Each player drives a 3-bit one-hot move. A combinational `valid` flags rounds where both players played exactly one option.
- A registered side-channel adds per-player error classification, encoded moves, a sampled-round strobe and a saturating invalid-round counter.

---
 rtl/rps_pkg.sv | 29 ++
 rtl/valid_io_onehot3_check.sv | 38 +++
 rtl/valid_io.sv | 117 +++++++++++
 tb/tb_valid_io.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared types and constants for the rock-paper-scissors input path.
package rps_pkg;

   // Encoded move handed to the winner-decision logic.
   typedef enum logic [1:0] {
      MV_INVALID  = 2'd0,
      MV_SCISSORS = 2'd1,
      MV_ROCK     = 2'd2,
      MV_PAPER    = 2'd3
   } move_e;

   // Per-player legality classification; 2'b11 is never produced.
   typedef enum logic [1:0] {
      ERR_OK    = 2'b00,
      ERR_NONE  = 2'b01,
      ERR_MULTI = 2'b10
   } err_e;

   // Bit positions inside the one-hot move vector.
   localparam int SCISSORS_BIT = 0;
   localparam int ROCK_BIT     = 1;
   localparam int PAPER_BIT    = 2;

   // Number of options selected in a 3-bit move vector.
   function automatic logic [1:0] popcount3(input logic [2:0] vec);
      return {1'b0, vec[0]} + {1'b0, vec[1]} + {1'b0, vec[2]};
   endfunction

endpackage : rps_pkg

// File: rtl/valid_io_onehot3_check.sv
// Combinational legality check and move encoder for one player.
module onehot3_check
   import rps_pkg::*;
(
   input  logic [2:0] vec,
   output logic       ok,
   output err_e       err,
   output move_e      move
);

   logic [1:0] pop;

   assign pop = popcount3(vec);

   // Classify the vector by how many options are set, then encode the single choice.
   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      ok   = 1'b0;
      err  = ERR_MULTI;
      move = MV_INVALID;
      case (pop)
         2'd0: err = ERR_NONE;
         2'd1: begin
            ok  = 1'b1;
            err = ERR_OK;
            if (vec[SCISSORS_BIT]) begin
               move = MV_SCISSORS;
            end else if (vec[ROCK_BIT]) begin
               move = MV_ROCK;
            end else begin
               move = MV_PAPER;
            end
         end
         default: err = ERR_MULTI;
      endcase
   end

endmodule : onehot3_check

// File: rtl/valid_io.sv
// Input-legality checker: combinational valid plus a registered side-channel
// with per-player error codes, encoded moves and saturating round counters.
module valid_io
   import rps_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       inA,
   input  logic [2:0]       inB,
   input  logic             in_vld,
   output logic             valid,
   output logic             out_vld,
   output logic [1:0]       a_err,
   output logic [1:0]       b_err,
   output logic [1:0]       moveA,
   output logic [1:0]       moveB,
   output logic             round_valid,
   output logic [CNT_W-1:0] invalid_cnt,
   output logic [CNT_W-1:0] round_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic  ok_a, ok_b;
   err_e  err_a, err_b;
   move_e mv_a, mv_b;

   logic             out_vld_d,     out_vld_q;
   err_e             a_err_d,       a_err_q;
   err_e             b_err_d,       b_err_q;
   move_e            move_a_d,      move_a_q;
   move_e            move_b_d,      move_b_q;
   logic             round_valid_d, round_valid_q;
   logic [CNT_W-1:0] invalid_cnt_d, invalid_cnt_q;
   logic [CNT_W-1:0] round_cnt_d,   round_cnt_q;

   onehot3_check u_check_a (
      .vec  (inA),
      .ok   (ok_a),
      .err  (err_a),
      .move (mv_a)
   );

   onehot3_check u_check_b (
      .vec  (inB),
      .ok   (ok_b),
      .err  (err_b),
      .move (mv_b)
   );

   // Round legality is pure logic so it never waits on a clock or reset.
   assign valid = ok_a & ok_b;

   // Next-state: capture a sampled round and bump the counters, otherwise hold.
   always_comb begin
      out_vld_d     = 1'b0;
      a_err_d       = a_err_q;
      b_err_d       = b_err_q;
      move_a_d      = move_a_q;
      move_b_d      = move_b_q;
      round_valid_d = round_valid_q;
      invalid_cnt_d = invalid_cnt_q;
      round_cnt_d   = round_cnt_q;
      if (in_vld) begin
         out_vld_d     = 1'b1;
         a_err_d       = err_a;
         b_err_d       = err_b;
         move_a_d      = mv_a;
         move_b_d      = mv_b;
         round_valid_d = valid;
         if (round_cnt_q != CNT_MAX) begin
            round_cnt_d = round_cnt_q + CNT_ONE;
         end
         if (!valid && (invalid_cnt_q != CNT_MAX)) begin
            invalid_cnt_d = invalid_cnt_q + CNT_ONE;
         end
      end
   end

   // State registers with asynchronous active-high clear.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: all state here is a handful of control flops, so every one is cleared by reset.
      if (rst) begin
         out_vld_q     <= 1'b0;
         a_err_q       <= ERR_NONE;
         b_err_q       <= ERR_NONE;
         move_a_q      <= MV_INVALID;
         move_b_q      <= MV_INVALID;
         round_valid_q <= 1'b0;
         invalid_cnt_q <= '0;
         round_cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         out_vld_q     <= out_vld_d;
         a_err_q       <= a_err_d;
         b_err_q       <= b_err_d;
         move_a_q      <= move_a_d;
         move_b_q      <= move_b_d;
         round_valid_q <= round_valid_d;
         invalid_cnt_q <= invalid_cnt_d;
         round_cnt_q   <= round_cnt_d;
      end
   end

   assign out_vld     = out_vld_q;
   assign a_err       = a_err_q;
   assign b_err       = b_err_q;
   assign moveA       = move_a_q;
   assign moveB       = move_b_q;
   assign round_valid = round_valid_q;
   assign invalid_cnt = invalid_cnt_q;
   assign round_cnt   = round_cnt_q;

endmodule : valid_io

// File: tb/tb_valid_io.sv
// Self-checking bench for valid_io: directed steps plus random rounds
// compared against a popcount-based reference model. A second instance
// with 2-bit counters exercises saturation.
module tb_valid_io;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst;
   logic [2:0] in_a, in_b;
   logic       in_vld;

   logic       valid, out_vld, round_valid;
   logic [1:0] a_err, b_err, move_a, move_b;
   logic [7:0] invalid_cnt, round_cnt;

   logic       valid_s, out_vld_s, round_valid_s;
   logic [1:0] a_err_s, b_err_s, move_a_s, move_b_s;
   logic [1:0] invalid_cnt_s, round_cnt_s;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   int m_ovld, m_aerr, m_berr, m_ma, m_mb, m_rv;
   int m_inv, m_rnd, m_inv_s, m_rnd_s;

   valid_io #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .inA(in_a), .inB(in_b), .in_vld(in_vld),
      .valid(valid), .out_vld(out_vld), .a_err(a_err), .b_err(b_err),
      .moveA(move_a), .moveB(move_b), .round_valid(round_valid),
      .invalid_cnt(invalid_cnt), .round_cnt(round_cnt)
   );

   valid_io #(.CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .inA(in_a), .inB(in_b), .in_vld(in_vld),
      .valid(valid_s), .out_vld(out_vld_s), .a_err(a_err_s), .b_err(b_err_s),
      .moveA(move_a_s), .moveB(move_b_s), .round_valid(round_valid_s),
      .invalid_cnt(invalid_cnt_s), .round_cnt(round_cnt_s)
   );

   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_err(input logic [2:0] v);
      case ($countones(v))
         0:       return 1;
         1:       return 0;
         default: return 2;
      endcase
   endfunction

   // A legal move is the index of its set bit plus one; anything else is 0.
   function automatic int ref_move(input logic [2:0] v);
      if ($countones(v) != 1) return 0;
      return $clog2(int'(v)) + 1;
   endfunction

   function automatic int ref_valid(input logic [2:0] a, input logic [2:0] b);
      return ($countones(a) == 1 && $countones(b) == 1) ? 1 : 0;
   endfunction

   function automatic int sat_inc(input int v, input int max);
      return (v >= max) ? max : v + 1;
   endfunction

   task automatic model_reset();
      m_ovld = 0; m_aerr = 1; m_berr = 1; m_ma = 0; m_mb = 0; m_rv = 0;
      m_inv = 0; m_rnd = 0; m_inv_s = 0; m_rnd_s = 0;
   endtask

   task automatic model_sample();
      if (in_vld) begin
         m_ovld  = 1;
         m_aerr  = ref_err(in_a);
         m_berr  = ref_err(in_b);
         m_ma    = ref_move(in_a);
         m_mb    = ref_move(in_b);
         m_rv    = ref_valid(in_a, in_b);
         m_rnd   = sat_inc(m_rnd, 255);
         m_rnd_s = sat_inc(m_rnd_s, 3);
         if (m_rv == 0) begin
            m_inv   = sat_inc(m_inv, 255);
            m_inv_s = sat_inc(m_inv_s, 3);
         end
      end else begin
         m_ovld = 0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out_vld"},     32'(out_vld),       32'(m_ovld));
      check({tag, ".a_err"},       32'(a_err),         32'(m_aerr));
      check({tag, ".b_err"},       32'(b_err),         32'(m_berr));
      check({tag, ".moveA"},       32'(move_a),        32'(m_ma));
      check({tag, ".moveB"},       32'(move_b),        32'(m_mb));
      check({tag, ".round_valid"}, 32'(round_valid),   32'(m_rv));
      check({tag, ".invalid_cnt"}, 32'(invalid_cnt),   32'(m_inv));
      check({tag, ".round_cnt"},   32'(round_cnt),     32'(m_rnd));
      check({tag, ".s.out_vld"},   32'(out_vld_s),     32'(m_ovld));
      check({tag, ".s.inv_cnt"},   32'(invalid_cnt_s), 32'(m_inv_s));
      check({tag, ".s.rnd_cnt"},   32'(round_cnt_s),   32'(m_rnd_s));
   endtask

   // Drive one cycle of stimulus at the falling edge, check after the rising edge.
   task automatic cycle(input string tag, input logic [2:0] a, input logic [2:0] b, input logic v);
      @(negedge clk);
      in_a = a; in_b = b; in_vld = v;
      #1;
      check({tag, ".valid"}, 32'(valid), 32'(ref_valid(a, b)));
      @(posedge clk);
      model_sample();
      #1;
      check_all(tag);
   endtask

   logic [2:0] comb_a [9] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b101, 3'b111, 3'b001, 3'b001, 3'b001};
   logic [2:0] comb_b [9] = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b000, 3'b011, 3'b111};
   logic       comb_v [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      // Reset state with the clock idle.
      rst = 1'b1; in_a = 3'b000; in_b = 3'b000; in_vld = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      rst = 1'b0;
      #1;

      // Combinational legality with no clock edges at all.
      for (int i = 0; i < 9; i++) begin
         in_a = comb_a[i]; in_b = comb_b[i];
         #1;
         check($sformatf("comb%0d.valid", i), 32'(valid), 32'(comb_v[i]));
         check($sformatf("comb%0d.valid_s", i), 32'(valid_s), 32'(comb_v[i]));
      end
      check_all("comb_hold");

      clk_en = 1'b1;

      // Registered classification of an illegal round.
      cycle("cls", 3'b000, 3'b011, 1'b1);
      check("cls.a_err_const", 32'(a_err), 32'h1);
      check("cls.b_err_const", 32'(b_err), 32'h2);
      check("cls.inv_const", 32'(invalid_cnt), 32'h1);

      // Move encoding on legal rounds, back to back.
      cycle("mv1", 3'b001, 3'b100, 1'b1);
      check("mv1.moves_const", 32'({move_a, move_b}), 32'h7);
      cycle("mv2", 3'b010, 3'b010, 1'b1);
      check("mv2.moves_const", 32'({move_a, move_b}), 32'ha);

      // Strobe gating: inputs move, registers hold.
      cycle("gate1", 3'b111, 3'b000, 1'b0);
      cycle("gate2", 3'b100, 3'b001, 1'b0);

      // Saturation of the 2-bit instance with 5 back-to-back illegal rounds.
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_sat");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cycle($sformatf("sat%0d", i), 3'b110, 3'b001, 1'b1);
      check("sat.inv_s_const", 32'(invalid_cnt_s), 32'h3);
      check("sat.rnd_s_const", 32'(round_cnt_s), 32'h3);
      check("sat.inv8_const", 32'(invalid_cnt), 32'h5);

      // Asynchronous reset between clock edges, mid-stream.
      cycle("pre_rst", 3'b001, 3'b010, 1'b1);
      @(negedge clk);
      in_a = 3'b111; in_b = 3'b010; in_vld = 1'b1;
      @(posedge clk);
      model_sample();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_mid");
      check("rst_mid.valid", 32'(valid), 32'(ref_valid(in_a, in_b)));
      in_a = 3'b100;
      #1;
      check("rst_mid.valid2", 32'(valid), 32'(ref_valid(in_a, in_b)));
      @(posedge clk);
      #1;
      check_all("rst_hold");
      @(negedge clk);
      rst = 1'b0; in_vld = 1'b0;

      // Random rounds against the model.
      for (int i = 0; i < 300; i++) begin
         cycle("rand", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) != 0));
      end

      // Continuous sampling pushes the 8-bit round counter into saturation.
      for (int i = 0; i < 300; i++) begin
         cycle("burst", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1);
      end
      check("burst.rnd_sat_const", 32'(round_cnt), 32'hff);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_valid_io
